// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser, per-channel stability counter and
// registered press/release event pulses for up to 32 raw button/switch lines.
module button_debouncer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RAW_IDLE = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] sync_s1;
  logic [WIDTH-1:0] sync_s2;
  logic [WIDTH-1:0] pressed_c;
  logic [CNT_W-1:0] cnt [WIDTH];

  // Two-flop synchroniser; resets to the idle pin level so reset release is quiet
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_s1 <= RAW_IDLE;
      sync_s2 <= RAW_IDLE;
    end else begin
      sync_s1 <= in_raw;
      sync_s2 <= sync_s1;
    end
  end

  // Normalise polarity so that 1 always means pressed
  always_comb begin
    pressed_c = ACTIVE_LOW ? ~sync_s2 : sync_s2;
  end

  // Per-channel stability count; level flips only after an unbroken mismatch run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      press         <= '0;
      release_pulse <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (pressed_c[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]           <= '0;
          level[i]         <= pressed_c[i];
          press[i]         <= pressed_c[i];
          release_pulse[i] <= ~pressed_c[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: active-low and active-high instances,
// STABLE_CYCLES = 4, hand-computed expected levels and pulses.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] level_a, press_a, rel_a;
  logic [7:0] level_b, press_b, rel_b;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_debouncer #(.WIDTH(8), .STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_raw(in_a),
    .level(level_a), .press(press_a), .release_pulse(rel_a)
  );

  button_debouncer #(.WIDTH(8), .STABLE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_raw(in_b),
    .level(level_b), .press(press_b), .release_pulse(rel_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and check both instances against expected outputs
  task automatic step(input string tag,
                      input logic [7:0] la, input logic [7:0] pa, input logic [7:0] ra,
                      input logic [7:0] lb, input logic [7:0] pb, input logic [7:0] rb);
    tick();
    chk({tag, ".level_a"}, level_a, la);
    chk({tag, ".press_a"}, press_a, pa);
    chk({tag, ".rel_a"},   rel_a,   ra);
    chk({tag, ".level_b"}, level_b, lb);
    chk({tag, ".press_b"}, press_b, pb);
    chk({tag, ".rel_b"},   rel_b,   rb);
  endtask

  // n edges with steady levels and no pulses
  task automatic quiet(input string tag, input int n, input logic [7:0] la, input logic [7:0] lb);
    for (int j = 0; j < n; j++) begin
      step(tag, la, 8'h00, 8'h00, lb, 8'h00, 8'h00);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_a  = 8'hFF;
    in_b  = 8'h00;

    // Reset idle
    quiet("reset_hold", 3, 8'h00, 8'h00);
    rst_n = 1'b1;
    quiet("reset_idle", 20, 8'h00, 8'h00);

    // Clean press/release on bit 0: input set before edge k, event at edge k+5
    in_a = 8'hFE;
    quiet("b0_press_wait", 5, 8'h00, 8'h00);
    step("b0_press", 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    quiet("b0_held", 3, 8'h01, 8'h00);
    in_a = 8'hFF;
    quiet("b0_rel_wait", 5, 8'h01, 8'h00);
    step("b0_release", 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00);
    quiet("b0_idle", 3, 8'h00, 8'h00);

    // Bounce on bit 3: low 3, high 1, low 2, then high
    in_a = 8'hF7; quiet("b3_bounce_l3", 3, 8'h00, 8'h00);
    in_a = 8'hFF; quiet("b3_bounce_h1", 1, 8'h00, 8'h00);
    in_a = 8'hF7; quiet("b3_bounce_l2", 2, 8'h00, 8'h00);
    in_a = 8'hFF; quiet("b3_bounce_h",  8, 8'h00, 8'h00);
    // Then a solid 10-cycle hold
    in_a = 8'hF7;
    quiet("b3_hold_wait", 5, 8'h00, 8'h00);
    step("b3_press", 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00);
    quiet("b3_hold", 4, 8'h08, 8'h00);
    in_a = 8'hFF;
    quiet("b3_rel_wait", 5, 8'h08, 8'h00);
    step("b3_release", 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00);
    quiet("b3_idle", 2, 8'h00, 8'h00);

    // All channels at once
    in_a = 8'h00;
    quiet("all_wait", 5, 8'h00, 8'h00);
    step("all_press", 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    quiet("all_held", 2, 8'hFF, 8'h00);
    in_a = 8'hFF;
    quiet("all_rel_wait", 5, 8'hFF, 8'h00);
    step("all_release", 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
    quiet("all_idle", 2, 8'h00, 8'h00);

    // Reset mid-count on bit 2: the count restarts after the reset edge
    in_a = 8'hFB;
    quiet("mid_pre", 2, 8'h00, 8'h00);
    rst_n = 1'b0;
    quiet("mid_reset", 1, 8'h00, 8'h00);
    rst_n = 1'b1;
    quiet("mid_wait", 5, 8'h00, 8'h00);
    step("mid_press", 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00);
    quiet("mid_held", 2, 8'h04, 8'h00);
    in_a = 8'hFF;
    quiet("mid_rel_wait", 5, 8'h04, 8'h00);
    step("mid_release", 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);

    // Active-high instance: raw 1 means pressed
    in_b = 8'h01;
    quiet("pol_wait", 5, 8'h00, 8'h00);
    step("pol_press", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00);
    quiet("pol_held", 2, 8'h00, 8'h01);
    in_b = 8'h00;
    quiet("pol_rel_wait", 5, 8'h00, 8'h01);
    step("pol_release", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    quiet("pol_idle", 2, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
